// File: rtl/light_pkg.sv
// Shared state encoding, default timing constants and output decode helpers
// for the smart-lighting mode controller.
package light_pkg;

    typedef enum logic [2:0] {
        AUTO_OFF   = 3'd0,
        AUTO_ON    = 3'd1,
        AUTO_WARN  = 3'd2,
        MANUAL_OFF = 3'd3,
        MANUAL_ON  = 3'd4
    } light_state_t;

    localparam int DEF_DEB_CYCLES  = 1000;
    localparam int DEF_LONG_CYCLES = 2000000;
    localparam int DEF_HOLD_CYCLES = 3000;
    localparam int DEF_WARN_CYCLES = 500;
    localparam int DEF_BLINK_HALF  = 50;

    function automatic logic is_manual(input light_state_t s);
        return (s == MANUAL_OFF) || (s == MANUAL_ON);
    endfunction

    function automatic logic lamp_level(input light_state_t s, input logic blink);
        logic lvl;
        lvl = 1'b0;
        case (s)
            AUTO_ON, MANUAL_ON: lvl = 1'b1;
            AUTO_WARN:          lvl = blink;
            default:            lvl = 1'b0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button front end: 2-FF synchronizer, stability debounce and a
// short/long press classifier that stays disarmed until a real release.
module button_debounce
    import light_pkg::*;
#(
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int LONG_CYCLES = DEF_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic push_button,
    output logic short_ev,
    output logic long_ev
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int LW = $clog2(LONG_CYCLES + 1);

    logic          btn_meta;
    logic          btn_s;
    logic          btn_d;
    logic [1:0]    sync_fill;
    logic [DW-1:0] deb_cnt;
    logic [LW-1:0] press_cnt;
    logic          armed;
    logic          long_done;

    // sync_fill marks when btn_s reflects the pin again rather than reset zeros
    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_meta  <= 1'b0;
            btn_s     <= 1'b0;
            sync_fill <= 2'b00;
        end else begin
            btn_meta  <= push_button;
            btn_s     <= btn_meta;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_d   <= 1'b0;
            deb_cnt <= '0;
        end else if (btn_s == btn_d) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
            btn_d   <= btn_s;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + DW'(1);
        end
    end

    // A nonzero press count with btn_d low marks the first cycle after release
    always_ff @(posedge clk) begin
        if (!rst) begin
            press_cnt <= '0;
            long_done <= 1'b0;
            armed     <= 1'b0;
            short_ev  <= 1'b0;
            long_ev   <= 1'b0;
        end else begin
            short_ev <= 1'b0;
            long_ev  <= 1'b0;
            if (sync_fill[1] && !btn_s && !btn_d) begin
                armed <= 1'b1;
            end
            if (btn_d) begin
                if (press_cnt != LW'(LONG_CYCLES)) begin
                    press_cnt <= press_cnt + LW'(1);
                end
                if (press_cnt == LW'(LONG_CYCLES - 1)) begin
                    long_done <= 1'b1;
                    long_ev   <= armed;
                end
            end else if (press_cnt != '0) begin
                short_ev  <= armed && !long_done;
                press_cnt <= '0;
                long_done <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/light_mode_ctrl.sv
// Lamp mode/timing controller: automatic motion-driven operation with a
// retriggerable hold and blinking warning, plus manual button toggling.
module light_mode_ctrl
    import light_pkg::*;
#(
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int LONG_CYCLES = DEF_LONG_CYCLES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int WARN_CYCLES = DEF_WARN_CYCLES,
    parameter int BLINK_HALF  = DEF_BLINK_HALF
) (
    input  logic clk,
    input  logic rst,
    input  logic push_button,
    input  logic infravermelho,
    output logic led,
    output logic saida
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int WW = $clog2(WARN_CYCLES + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);

    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
    localparam logic [WW-1:0] WARN_LOAD  = WW'(WARN_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic pir_meta;
    logic pir_s;
    logic short_ev;
    logic long_ev;
    logic retrigger;

    light_state_t  state;
    light_state_t  state_nxt;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nxt;
    logic [WW-1:0] warn_cnt;
    logic [WW-1:0] warn_nxt;
    logic [BW-1:0] blink_cnt;
    logic [BW-1:0] blink_cnt_nxt;
    logic          blink_ph;
    logic          blink_ph_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pir_meta <= 1'b0;
            pir_s    <= 1'b0;
        end else begin
            pir_meta <= infravermelho;
            pir_s    <= pir_meta;
        end
    end

    button_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .LONG_CYCLES(LONG_CYCLES)
    ) u_button (
        .clk        (clk),
        .rst        (rst),
        .push_button(push_button),
        .short_ev   (short_ev),
        .long_ev    (long_ev)
    );

    assign retrigger = pir_s || short_ev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= AUTO_OFF;
            hold_cnt  <= '0;
            warn_cnt  <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            warn_cnt  <= warn_nxt;
            blink_cnt <= blink_cnt_nxt;
            blink_ph  <= blink_ph_nxt;
        end
    end

    // Branch order encodes priority: long press, then short press/motion, then expiry
    always_comb begin
        state_nxt     = state;
        hold_nxt      = hold_cnt;
        warn_nxt      = warn_cnt;
        blink_cnt_nxt = blink_cnt;
        blink_ph_nxt  = blink_ph;
        case (state)
            AUTO_OFF: begin
                if (long_ev) begin
                    state_nxt = MANUAL_OFF;
                end else if (retrigger) begin
                    state_nxt = AUTO_ON;
                    hold_nxt  = HOLD_LOAD;
                end
            end
            AUTO_ON: begin
                if (long_ev) begin
                    state_nxt = MANUAL_ON;
                end else if (retrigger) begin
                    hold_nxt = HOLD_LOAD;
                end else if (hold_cnt == '0) begin
                    state_nxt     = AUTO_WARN;
                    warn_nxt      = WARN_LOAD;
                    blink_cnt_nxt = '0;
                    blink_ph_nxt  = 1'b0;
                end else begin
                    hold_nxt = hold_cnt - HW'(1);
                end
            end
            AUTO_WARN: begin
                if (long_ev) begin
                    state_nxt = MANUAL_ON;
                end else if (retrigger) begin
                    state_nxt = AUTO_ON;
                    hold_nxt  = HOLD_LOAD;
                end else if (warn_cnt == '0) begin
                    state_nxt = AUTO_OFF;
                end else begin
                    warn_nxt = warn_cnt - WW'(1);
                    if (blink_cnt == BLINK_LAST) begin
                        blink_cnt_nxt = '0;
                        blink_ph_nxt  = ~blink_ph;
                    end else begin
                        blink_cnt_nxt = blink_cnt + BW'(1);
                    end
                end
            end
            MANUAL_OFF: begin
                if (long_ev) begin
                    state_nxt = AUTO_OFF;
                end else if (short_ev) begin
                    state_nxt = MANUAL_ON;
                end
            end
            MANUAL_ON: begin
                if (long_ev) begin
                    state_nxt = AUTO_ON;
                    hold_nxt  = HOLD_LOAD;
                end else if (short_ev) begin
                    state_nxt = MANUAL_OFF;
                end
            end
            default: begin
                state_nxt = AUTO_OFF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            saida <= 1'b0;
            led   <= 1'b0;
        end else begin
            saida <= lamp_level(state, blink_ph);
            led   <= is_manual(state);
        end
    end

endmodule

// File: tb/tb_light_mode_ctrl.sv
// Directed self-checking bench for light_mode_ctrl using shortened timing
// parameters; expected lamp/indicator values are computed cycle by cycle.
module tb_light_mode_ctrl;
    import light_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic push_button;
    logic infravermelho;
    logic led;
    logic saida;

    int checks = 0;
    int errors = 0;
    int short_cnt = 0;
    int long_cnt = 0;
    int sc0;
    int lc0;

    light_mode_ctrl #(
        .DEB_CYCLES (4),
        .LONG_CYCLES(20),
        .HOLD_CYCLES(30),
        .WARN_CYCLES(10),
        .BLINK_HALF (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .push_button  (push_button),
        .infravermelho(infravermelho),
        .led          (led),
        .saida        (saida)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dut.u_button.short_ev === 1'b1) short_cnt++;
        if (dut.u_button.long_ev === 1'b1) long_cnt++;
    end

    task automatic applyStimulus(input logic btn, input logic pir);
        push_button   = btn;
        infravermelho = pir;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic exp_saida, input logic exp_led);
        checks++;
        assert (saida === exp_saida) else begin
            errors++;
            $error("[TB] FAIL %s saida got %b expected %b", tag, saida, exp_saida);
        end
        checks++;
        assert (led === exp_led) else begin
            errors++;
            $error("[TB] FAIL %s led got %b expected %b", tag, led, exp_led);
        end
    endtask

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("[TB] FAIL %s got %0d expected %0d", tag, got, want);
        end
    endtask

    // Lamp level i edges after the stimulus start: on from on_from, blink
    // 0,0,1,1,... for 10 edges from warn_from, then off.
    function automatic logic exp_auto(input int i, input int on_from, input int warn_from);
        if (i < on_from) return 1'b0;
        if (i < warn_from) return 1'b1;
        if (i < warn_from + 10) return (((i - warn_from) / 2) % 2) == 1;
        return 1'b0;
    endfunction

    initial begin
        rst = 1'b0;
        push_button = 1'b0;
        infravermelho = 1'b0;

        $display("[TB] reset with random inputs");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'($urandom_range(1)), 1'($urandom_range(1)));
            checkOutput("reset", 1'b0, 1'b0);
        end
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkVal("reset_state", 32'(dut.state), 32'(AUTO_OFF));
        checkOutput("post_reset", 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0);

        $display("[TB] auto cycle");
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b0, i < 5);
            checkOutput($sformatf("auto_%0d", i), exp_auto(i, 3, 37), 1'b0);
        end

        $display("[TB] retrigger during warning");
        for (int i = 0; i < 81; i++) begin
            applyStimulus(1'b0, (i == 0) || (i == 35));
            checkOutput($sformatf("retrig_%0d", i),
                        (i <= 37) ? exp_auto(i, 3, 33) : exp_auto(i, 38, 68), 1'b0);
        end

        $display("[TB] long press to manual");
        sc0 = short_cnt;
        lc0 = long_cnt;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(i < 30, 1'b0);
            if (i == 26) checkOutput("to_manual_pre", 1'b0, 1'b0);
            if (i == 27) checkOutput("to_manual_led", 1'b0, 1'b1);
        end
        checkOutput("manual_off", 1'b0, 1'b1);
        checkVal("to_manual_long", 32'(long_cnt - lc0), 32'd1);
        checkVal("to_manual_short", 32'(short_cnt - sc0), 32'd0);

        $display("[TB] bouncy short press");
        sc0 = short_cnt;
        lc0 = long_cnt;
        for (int i = 0; i < 30; i++) begin
            applyStimulus((i < 4) ? (i % 2 == 0) : (i < 12), 1'b0);
            if (i == 19) checkOutput("bounce_pre", 1'b0, 1'b1);
            if (i == 20) checkOutput("bounce_on", 1'b1, 1'b1);
        end
        checkVal("bounce_short", 32'(short_cnt - sc0), 32'd1);
        checkVal("bounce_long", 32'(long_cnt - lc0), 32'd0);

        sc0 = short_cnt;
        for (int i = 0; i < 25; i++) begin
            applyStimulus(i < 8, 1'b0);
            if (i == 15) checkOutput("second_pre", 1'b1, 1'b1);
            if (i == 16) checkOutput("second_off", 1'b0, 1'b1);
        end
        checkVal("second_short", 32'(short_cnt - sc0), 32'd1);

        $display("[TB] motion ignored in manual");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, (i >= 2) && (i < 5));
            checkOutput($sformatf("manual_pir_%0d", i), 1'b0, 1'b1);
        end

        for (int i = 0; i < 40; i++) begin
            applyStimulus(i < 30, 1'b0);
            if (i == 26) checkOutput("to_auto_pre", 1'b0, 1'b1);
            if (i == 27) checkOutput("to_auto_led", 1'b0, 1'b0);
        end

        $display("[TB] long press while lamp on");
        sc0 = short_cnt;
        lc0 = long_cnt;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(i < 30, i == 0);
            if (i == 3)  checkOutput("lp_on", 1'b1, 1'b0);
            if (i == 26) checkOutput("lp_pre", 1'b1, 1'b0);
            if (i == 27) checkOutput("lp_led", 1'b1, 1'b1);
            if (i == 29) checkOutput("lp_held", 1'b1, 1'b1);
        end
        checkOutput("lp_released", 1'b1, 1'b1);
        checkVal("lp_short", 32'(short_cnt - sc0), 32'd0);
        checkVal("lp_long", 32'(long_cnt - lc0), 32'd1);

        for (int i = 0; i < 70; i++) begin
            applyStimulus(i < 30, 1'b0);
            if (i <= 26) checkOutput($sformatf("back_auto_%0d", i), 1'b1, 1'b1);
            else         checkOutput($sformatf("back_auto_%0d", i), exp_auto(i, 0, 57), 1'b0);
        end
        checkVal("back_auto_state", 32'(dut.state), 32'(AUTO_OFF));

        $display("[TB] reset during press and hold");
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, i == 0);
        checkOutput("pre_rst_on", 1'b1, 1'b0);
        sc0 = short_cnt;
        lc0 = long_cnt;
        for (int i = 0; i < 55; i++) begin
            rst = (i != 10);
            applyStimulus(i < 41, 1'b0);
            if (i == 9)  checkOutput("mid_press_on", 1'b1, 1'b0);
            if (i >= 10) checkOutput($sformatf("held_rst_%0d", i), 1'b0, 1'b0);
        end
        rst = 1'b1;
        checkVal("held_rst_short", 32'(short_cnt - sc0), 32'd0);
        checkVal("held_rst_long", 32'(long_cnt - lc0), 32'd0);

        sc0 = short_cnt;
        for (int i = 0; i < 25; i++) begin
            applyStimulus(i < 8, 1'b0);
            if (i == 15) checkOutput("rearm_pre", 1'b0, 1'b0);
            if (i == 16) checkOutput("rearm_on", 1'b1, 1'b0);
        end
        checkVal("rearm_short", 32'(short_cnt - sc0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
